execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Y86-64 pipeline E stage, directly downstream of decode. Holds the E pipeline register
//  (loaded from decode's d_* outputs), ALU, condition-code register (ZF/SF/OF) and Cnd logic.
//  Drives e_valE/e_dstE back to decode's forwarding network and E_* to memory stage/hazard unit.
// PARAMETERS
//  WIDTH     64     datapath width (valA/valB/valC/valE)
//  REG_NONE  4'hF   "no register" id; also bubble value for dst/src fields
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  E_bubble       in   1      load bubble into E register this edge
//  d_stat         in   3      decode status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//  d_icode/d_ifun in   4/4    decode icode/ifun
//  d_valC         in   WIDTH  constant
//  d_valA/d_valB  in   WIDTH  forwarded operands
//  d_dstE/d_dstM  in   4/4    destination ids
//  d_srcA/d_srcB  in   4/4    source ids (kept for load-use hazard detection)
//  m_stat         in   3      memory-stage status (combinational)
//  W_stat         in   3      writeback-stage status
//  E_stat,E_icode,E_ifun  out 3/4/4   registered E fields
//  E_valC,E_valA,E_valB   out WIDTH   registered E operands
//  E_dstE,E_dstM,E_srcA,E_srcB out 4  registered E register ids
//  e_valE         out  WIDTH  ALU result (combinational from E_*)
//  e_dstE         out  4      REG_NONE if cmovXX not taken, else E_dstE
//  e_Cnd          out  1      condition result for jXX/cmovXX
//  cc             out  3      {ZF,SF,OF} register
//  perf_insn_cnt  out  32     only when EXEC_PERF_CNT_EN defined
// BEHAVIOUR
//  - E reg, each posedge: rst > E_bubble > load d_*. Reset/bubble value: stat=1, icode=1 (nop),
//    ifun=0, valC/valA/valB=0, dstE/dstM/srcA/srcB=REG_NONE. No stall input; load every cycle.
//  - aluA: valA for icode 2,6; valC for 3,4,5; -8 for 8,A; +8 for 9,B; else 0.
//  - aluB: valB for 4,5,6,8,9,A,B; 0 for 2,3; else 0.
//  - alufun: E_ifun if icode==6 else add. 0 add B+A, 1 sub B-A, 2 and, 3 xor; other ifun -> e_valE=0.
//  - Arithmetic mod 2^WIDTH. OF add: signs of A,B equal and result sign differs;
//    OF sub: signs of B,A differ and result sign differs from B; OF=0 for and/xor.
//  - set_cc = (E_icode==6) && m_stat in {2,3,4} false && W_stat in {2,3,4} false.
//    CC written at posedge when set_cc: ZF=(e_valE==0), SF=e_valE[WIDTH-1], OF as above.
//  - cc reset value {ZF,SF,OF}=3'b100; bubble does not touch cc.
//  - e_Cnd from cc and E_ifun: 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 ~ZF; 5 ~(SF^OF);
//    6 ~(SF^OF)&~ZF; 7+ 0. Combinational, zero-cycle latency from E register.
//  - e_dstE = REG_NONE when E_icode==2 && !e_Cnd; else E_dstE.
//  - Same-cycle: CC update from insn in E only affects Cnd of the following insn (next cycle).
//  - Reset mid-stream: E and cc return to reset values on that edge; no partial state kept.
// CONFIGURATION
//  EXEC_PERF_CNT_EN defined: 32-bit perf_insn_cnt, reset 0, +1 each posedge where E holds a
//   non-bubble insn (E_icode!=1 || E_stat!=1 excluded: counts E_icode!=1), wraps 0xFFFFFFFF->0;
//   rst clears. Not defined: port and counter absent, no other change.
// TESTING
//  - rst=1 one edge -> E_icode=1, E_dstE=E_dstM=E_srcA=E_srcB=F, cc=3'b100, e_Cnd=1 for ifun0.
//  - OPq sub valA=5 valB=5 -> e_valE=0; next edge cc=3'b100; following jne (ifun4) e_Cnd=0.
//  - OPq add valA=valB=0x4000_0000_0000_0000 -> e_valE=0x8000_0000_0000_0000, cc=3'b011.
//  - cmovl (ifun2) with cc=3'b000, dstE=3 -> e_dstE=F; with cc=3'b010 -> e_dstE=3.
//  - pushq valB=154 -> e_valE=146; popq valB=146 -> e_valE=154; cc unchanged.
//  - OPq with m_stat=3 -> cc not written; E_bubble=1 with valid d_* -> E loads nop bubble.

Source files
------------

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   Y86-64 pipeline execute (E) stage. Holds the E pipeline register loaded
//   from the decode stage, the ALU, the {ZF,SF,OF} condition-code register
//   and the branch/conditional-move condition logic.
//
//   e_valE / e_dstE feed decode's forwarding network. E_* fields feed the
//   memory stage and the hazard unit.
//
//   Optional build macro: EXEC_PERF_CNT_EN
//     When defined, adds a 32-bit perf_insn_cnt output. It counts every
//     clock edge at which E holds a non-nop instruction.
//     When undefined, the port and the counter do not exist.
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int         WIDTH    = 64,
    parameter logic [3:0] REG_NONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E_bubble,
    input  logic [2:0]       d_stat,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [WIDTH-1:0] d_valC,
    input  logic [WIDTH-1:0] d_valA,
    input  logic [WIDTH-1:0] d_valB,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic [2:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_Cnd,
    output logic [2:0]       cc
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]      perf_insn_cnt
`endif
);

    // Index of the sign bit of the datapath.
    localparam int MSB = WIDTH - 1;

    // Status codes.
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Instruction codes.
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU function codes.
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    // Condition-code value after reset: {ZF,SF,OF} = 1,0,0.
    localparam logic [2:0] CC_RESET = 3'b100;

    // Stack-pointer adjustments used by call/push (-8) and ret/pop (+8).
    localparam logic [WIDTH-1:0] POS_EIGHT = WIDTH'(8);
    localparam logic [WIDTH-1:0] NEG_EIGHT = ~POS_EIGHT + WIDTH'(1);

    // Returns 1 when a stage status is an exception (halt, bad address,
    // bad instruction). Any exception downstream inhibits the CC update.
    function automatic logic stat_is_exception(input logic [2:0] stat);
        logic hit;
        case (stat)
            STAT_HLT: hit = 1'b1;
            STAT_ADR: hit = 1'b1;
            STAT_INS: hit = 1'b1;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

    // ALU core. Returns {OF, result}. The result is B op A, mod 2^WIDTH.
    // Unknown function codes give a zero result and OF clear.
    function automatic logic [WIDTH:0] alu_eval(input logic [3:0]       fun,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        logic             of;
        case (fun)
            ALU_ADD: begin
                res = b + a;
                of  = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                res = b - a;
                of  = (b[MSB] != a[MSB]) && (res[MSB] != b[MSB]);
            end
            ALU_AND: begin
                res = b & a;
                of  = 1'b0;
            end
            ALU_XOR: begin
                res = b ^ a;
                of  = 1'b0;
            end
            default: begin
                res = {WIDTH{1'b0}};
                of  = 1'b0;
            end
        endcase
        return {of, res};
    endfunction

    // Branch / conditional-move condition. Evaluated against the {ZF,SF,OF}
    // flags and the instruction's function code.
    function automatic logic cond_eval(input logic [3:0] fun,
                                       input logic [2:0] flags);
        logic zf;
        logic sf;
        logic of;
        logic lt;
        logic res;
        zf = flags[2];
        sf = flags[1];
        of = flags[0];
        lt = sf ^ of;
        case (fun)
            4'h0:    res = 1'b1;
            4'h1:    res = lt | zf;
            4'h2:    res = lt;
            4'h3:    res = zf;
            4'h4:    res = ~zf;
            4'h5:    res = ~lt;
            4'h6:    res = ~lt & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic [3:0]       alufun_s;
    logic [WIDTH:0]   alu_out_s;
    logic             alu_of_s;
    logic             set_cc_s;

    // E pipeline register: reset and bubble both insert a nop; otherwise
    // load decode's outputs every cycle.
    always_ff @(posedge clk) begin
        if (rst || E_bubble) begin
            E_stat  <= STAT_AOK;
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_valC  <= {WIDTH{1'b0}};
            E_valA  <= {WIDTH{1'b0}};
            E_valB  <= {WIDTH{1'b0}};
            E_dstE  <= REG_NONE;
            E_dstM  <= REG_NONE;
            E_srcA  <= REG_NONE;
            E_srcB  <= REG_NONE;
        end else begin
            E_stat  <= d_stat;
            E_icode <= d_icode;
            E_ifun  <= d_ifun;
            E_valC  <= d_valC;
            E_valA  <= d_valA;
            E_valB  <= d_valB;
            E_dstE  <= d_dstE;
            E_dstM  <= d_dstM;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
        end
    end

    // ALU A operand: register operand, constant, or the stack adjustment.
    always_comb begin
        alu_a_s = {WIDTH{1'b0}};
        case (E_icode)
            I_RRMOVQ, I_OPQ:            alu_a_s = E_valA;
            I_IRMOVQ, I_RMMOVQ,
            I_MRMOVQ:                   alu_a_s = E_valC;
            I_CALL, I_PUSHQ:            alu_a_s = NEG_EIGHT;
            I_RET, I_POPQ:              alu_a_s = POS_EIGHT;
            default:                    alu_a_s = {WIDTH{1'b0}};
        endcase
    end

    // ALU B operand: valB for memory/stack/arith forms, zero for moves.
    always_comb begin
        alu_b_s = {WIDTH{1'b0}};
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET,
            I_PUSHQ, I_POPQ:            alu_b_s = E_valB;
            default:                    alu_b_s = {WIDTH{1'b0}};
        endcase
    end

    // ALU function select: only OPq uses its own ifun; all else adds.
    always_comb begin
        alufun_s = ALU_ADD;
        if (E_icode == I_OPQ) begin
            alufun_s = E_ifun;
        end else begin
            alufun_s = ALU_ADD;
        end
    end

    // ALU evaluation and condition-code write enable. An exception in the
    // memory or writeback stage suppresses the update, so a faulting
    // program leaves the flags it had before the fault.
    always_comb begin
        alu_out_s = alu_eval(alufun_s, alu_a_s, alu_b_s);
        alu_of_s  = alu_out_s[WIDTH];
        e_valE    = alu_out_s[WIDTH-1:0];
        set_cc_s  = (E_icode == I_OPQ)
                    && !stat_is_exception(m_stat)
                    && !stat_is_exception(W_stat);
    end

    // Condition-code register. Bubbles do not affect it; only OPq writes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc <= CC_RESET;
        end else if (set_cc_s) begin
            cc <= {(e_valE == {WIDTH{1'b0}}), e_valE[MSB], alu_of_s};
        end else begin
            cc <= cc;
        end
    end

    // Condition result and cmovXX destination squash. A cmov that is not
    // taken forwards no destination, so decode never sees a false write.
    always_comb begin
        e_Cnd  = cond_eval(E_ifun, cc);
        e_dstE = E_dstE;
        if ((E_icode == I_RRMOVQ) && !e_Cnd) begin
            e_dstE = REG_NONE;
        end else begin
            e_dstE = E_dstE;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    // Instruction counter: one count per edge that retires a non-nop from E.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_insn_cnt <= 32'd0;
        end else if (E_icode != I_NOP) begin
            perf_insn_cnt <= perf_insn_cnt + 32'd1;
        end else begin
            perf_insn_cnt <= perf_insn_cnt;
        end
    end
`else
    // Instruction counter not built in this configuration.
`endif

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//   Scoreboard bench for execute_stage. Each issued cycle runs an
//   instruction-level reference model. The model describes what each Y86
//   instruction computes; it does not describe operand muxes. The bench
//   queues the expected post-edge view of the stage. A separate monitor pops
//   one entry after every clock edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        E_bubble;
    logic [2:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [2:0]  cc;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_insn_cnt;
`endif

    execute_stage dut (
        .clk      (clk),
        .rst      (rst),
        .E_bubble (E_bubble),
        .d_stat   (d_stat),
        .d_icode  (d_icode),
        .d_ifun   (d_ifun),
        .d_valC   (d_valC),
        .d_valA   (d_valA),
        .d_valB   (d_valB),
        .d_dstE   (d_dstE),
        .d_dstM   (d_dstM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .E_stat   (E_stat),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valC   (E_valC),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_dstE   (E_dstE),
        .E_dstM   (E_dstM),
        .E_srcA   (E_srcA),
        .E_srcB   (E_srcB),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .e_Cnd    (e_Cnd),
        .cc       (cc)
`ifdef EXEC_PERF_CNT_EN
        ,
        .perf_insn_cnt (perf_insn_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        bubble;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [2:0]  m_stat;
        logic [2:0]  W_stat;
    } stim_t;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } ereg_t;

    typedef struct {
        ereg_t       e;
        logic [63:0] valE;
        logic [3:0]  dste;
        logic        cnd;
        logic [2:0]  cc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    ereg_t       m_e;
    logic [2:0]  m_cc;
    logic [31:0] m_cnt;
    int          tests;
    int          fails;

    // Reference model: what the instruction in E computes, by instruction meaning.
    function automatic void model_exec(input ereg_t e, output logic [63:0] v,
                                       output logic [2:0] flags);
        logic signed [64:0] wide;
        logic               of;
        v  = 64'd0;
        of = 1'b0;
        case (e.icode)
            4'h2: v = e.valA;                      // rrmovq / cmovXX
            4'h3: v = e.valC;                      // irmovq
            4'h4, 4'h5: v = e.valB + e.valC;       // effective address
            4'h6: begin
                case (e.ifun)
                    4'h0: begin
                        wide = $signed({e.valB[63], e.valB}) + $signed({e.valA[63], e.valA});
                        v = wide[63:0];
                        of = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
                    end
                    4'h1: begin
                        wide = $signed({e.valB[63], e.valB}) - $signed({e.valA[63], e.valA});
                        v = wide[63:0];
                        of = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
                    end
                    4'h2: v = e.valA & e.valB;
                    4'h3: v = e.valA ^ e.valB;
                    default: v = 64'd0;
                endcase
            end
            4'h8, 4'hA: v = e.valB - 64'd8;        // call / pushq
            4'h9, 4'hB: v = e.valB + 64'd8;        // ret / popq
            default: v = 64'd0;
        endcase
        flags = {(v == 64'd0), v[63], of};
    endfunction

    function automatic logic model_cnd(input logic [3:0] ifun, input logic [2:0] f);
        logic lt;
        lt = f[1] ^ f[0];
        case (ifun)
            4'h0: return 1'b1;
            4'h1: return lt || f[2];
            4'h2: return lt;
            4'h3: return f[2];
            4'h4: return !f[2];
            4'h5: return !lt;
            4'h6: return !lt && !f[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic ereg_t nop_e();
        ereg_t n;
        n.stat = 3'd1; n.icode = 4'h1; n.ifun = 4'h0;
        n.valC = 64'd0; n.valA = 64'd0; n.valB = 64'd0;
        n.dstE = 4'hF; n.dstM = 4'hF; n.srcA = 4'hF; n.srcB = 4'hF;
        return n;
    endfunction

    function automatic stim_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [3:0] dst);
        stim_t s;
        s.rst = 1'b0; s.bubble = 1'b0; s.stat = 3'd1;
        s.icode = icode; s.ifun = ifun; s.valA = a; s.valB = b; s.valC = c;
        s.dstE = dst; s.dstM = 4'hF; s.srcA = 4'h0; s.srcB = 4'h1;
        s.m_stat = 3'd1; s.W_stat = 3'd1;
        return s;
    endfunction

    // Drive one cycle, advance the model across the edge, queue the expectation.
    task automatic issue(input stim_t s);
        exp_t        x;
        logic [63:0] v;
        logic [2:0]  fl;
        rst = s.rst; E_bubble = s.bubble; d_stat = s.stat;
        d_icode = s.icode; d_ifun = s.ifun; d_valC = s.valC;
        d_valA = s.valA; d_valB = s.valB; d_dstE = s.dstE; d_dstM = s.dstM;
        d_srcA = s.srcA; d_srcB = s.srcB; m_stat = s.m_stat; W_stat = s.W_stat;
        if (s.rst) begin
            m_e = nop_e(); m_cc = 3'b100; m_cnt = 32'd0;
        end else begin
            if (m_e.icode == 4'h6 && !is_exc(s.m_stat) && !is_exc(s.W_stat)) begin
                model_exec(m_e, v, fl);
                m_cc = fl;
            end
            if (m_e.icode != 4'h1) m_cnt = m_cnt + 32'd1;
            if (s.bubble) begin
                m_e = nop_e();
            end else begin
                m_e.stat = s.stat; m_e.icode = s.icode; m_e.ifun = s.ifun;
                m_e.valC = s.valC; m_e.valA = s.valA; m_e.valB = s.valB;
                m_e.dstE = s.dstE; m_e.dstM = s.dstM; m_e.srcA = s.srcA; m_e.srcB = s.srcB;
            end
        end
        model_exec(m_e, v, fl);
        x.e = m_e; x.valE = v; x.cc = m_cc; x.cnt = m_cnt;
        x.cnd = model_cnd(m_e.ifun, m_cc);
        x.dste = (m_e.icode == 4'h2 && !x.cnd) ? 4'hF : m_e.dstE;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: after every edge, compare the stage against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("E_stat",  64'(E_stat),  64'(x.e.stat));
                chk("E_icode", 64'(E_icode), 64'(x.e.icode));
                chk("E_ifun",  64'(E_ifun),  64'(x.e.ifun));
                chk("E_valC",  E_valC,       x.e.valC);
                chk("E_valA",  E_valA,       x.e.valA);
                chk("E_valB",  E_valB,       x.e.valB);
                chk("E_dstE",  64'(E_dstE),  64'(x.e.dstE));
                chk("E_dstM",  64'(E_dstM),  64'(x.e.dstM));
                chk("E_srcA",  64'(E_srcA),  64'(x.e.srcA));
                chk("E_srcB",  64'(E_srcB),  64'(x.e.srcB));
                chk("e_valE",  e_valE,       x.valE);
                chk("e_dstE",  64'(e_dstE),  64'(x.dste));
                chk("e_Cnd",   64'(e_Cnd),   64'(x.cnd));
                chk("cc",      64'(cc),      64'(x.cc));
`ifdef EXEC_PERF_CNT_EN
                chk("perf_insn_cnt", 64'(perf_insn_cnt), 64'(x.cnt));
`endif
            end
        end
    end

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd5;
            2: return 64'h4000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'h8000_0000_0000_0000;
            5: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        stim_t s;
        tests = 0;
        fails = 0;
        s = mk(4'h6, 4'h0, 64'd7, 64'd9, 64'd3, 4'h2);
        s.rst = 1'b1;
        issue(s);                                                  // reset state
        issue(mk(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2));          // subq 5-5
        issue(mk(4'h7, 4'h4, 64'd0, 64'd0, 64'h100, 4'hF));        // jne, cc 100 -> not taken
        issue(mk(4'h6, 4'h0, 64'h4000_0000_0000_0000,
                 64'h4000_0000_0000_0000, 64'd0, 4'h2));           // addq overflow
        issue(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF));          // nop, cc -> 011
        issue(mk(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2));          // 1+1 -> cc 000
        issue(mk(4'h2, 4'h2, 64'd77, 64'd0, 64'd0, 4'h3));         // cmovl not taken
        issue(mk(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2));          // 0-1 -> cc 010
        issue(mk(4'h2, 4'h2, 64'd77, 64'd0, 64'd0, 4'h3));         // cmovl taken
        issue(mk(4'hA, 4'h0, 64'd1, 64'd154, 64'd0, 4'h4));        // pushq
        issue(mk(4'hB, 4'h0, 64'd1, 64'd146, 64'd0, 4'h4));        // popq
        issue(mk(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2));          // addq into E
        s = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
        s.m_stat = 3'd3;
        issue(s);                                                  // m_stat=ADR blocks cc
        s = mk(4'h6, 4'h3, 64'd9, 64'd9, 64'd2, 4'h5);
        s.bubble = 1'b1;
        issue(s);                                                  // bubble over valid d_*
        for (int i = 0; i < 400; i++) begin
            s.rst    = ($urandom_range(0, 39) == 0);
            s.bubble = ($urandom_range(0, 7) == 0);
            s.stat   = 3'($urandom_range(1, 4));
            s.icode  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
            s.ifun   = 4'($urandom_range(0, 8));
            s.valC   = rnd_val();
            s.valA   = rnd_val();
            s.valB   = rnd_val();
            s.dstE   = 4'($urandom_range(0, 15));
            s.dstM   = 4'($urandom_range(0, 15));
            s.srcA   = 4'($urandom_range(0, 15));
            s.srcB   = 4'($urandom_range(0, 15));
            s.m_stat = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            s.W_stat = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            issue(s);
        end
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
